// File: rtl/ma_stage.sv
// ma_stage: memory-access stage between EX and RW.
// Issues loads/stores to data memory over a registered req/ack handshake,
// stalls upstream while an access is outstanding, and registers the
// instruction bundle into the MA/RW latch.
// Optional build macro: MA_MISALIGN_TRAP_EN (misaligned ld/st trap with
// sticky misalign flag).
module ma_stage #(
  parameter int DATA_W = 32,
  parameter int CB_W   = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_PC,
  input  logic [DATA_W-1:0] in_ALU_Result,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [DATA_W-1:0] in_IR,
  input  logic [CB_W-1:0]   in_controlBus,
  output logic              ma_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              RW_valid,
  output logic [DATA_W-1:0] RW_PC,
  output logic [DATA_W-1:0] RW_Ld_Result,
  output logic [DATA_W-1:0] RW_ALU_Result,
  output logic [DATA_W-1:0] RW_IR,
  output logic [CB_W-1:0]   RW_controlBus
`ifdef MA_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t state, next_state;

  logic            is_mem;
  logic            trap;
  logic            mem_go;
  logic            issue;
  logic            pass;
  logic            complete;
  logic [CB_W-1:0] rw_cb_next;

  // A ld or st is any valid instruction with isSt or isLd set; isSt wins.
  assign is_mem = in_valid & (in_controlBus[0] | in_controlBus[1]);

`ifdef MA_MISALIGN_TRAP_EN
  assign trap = is_mem & (in_ALU_Result[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  assign mem_go = is_mem & ~trap;

  // State register for the IDLE/WAIT handshake controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state, stall and the one-hot action strobes for the datapath.
  always_comb begin
    next_state = state;
    ma_stall   = 1'b0;
    issue      = 1'b0;
    pass       = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_go) begin
          ma_stall   = 1'b1;
          issue      = 1'b1;
          next_state = ST_WAIT;
        end else if (in_valid) begin
          pass = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          complete   = 1'b1;
          next_state = ST_IDLE;
        end else begin
          ma_stall = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Control bits to latch; a trapped access must not write back.
  always_comb begin
    rw_cb_next = in_controlBus;
    if (pass && trap) rw_cb_next[6] = 1'b0;
  end

  // Memory request registers: set on issue, held through WAIT, dropped on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= in_controlBus[0];
      mem_addr  <= in_ALU_Result;
      mem_wdata <= in_op2;
    end else if (complete) begin
      mem_req <= 1'b0;
    end
  end

  // MA/RW latch: real instruction on pass-through or ack, otherwise a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RW_valid      <= 1'b0;
      RW_PC         <= '0;
      RW_Ld_Result  <= '0;
      RW_ALU_Result <= '0;
      RW_IR         <= '0;
      RW_controlBus <= '0;
    end else if (pass || complete) begin
      RW_valid      <= 1'b1;
      RW_PC         <= in_PC;
      RW_Ld_Result  <= (complete && !mem_we) ? mem_rdata : '0;
      RW_ALU_Result <= in_ALU_Result;
      RW_IR         <= in_IR;
      RW_controlBus <= rw_cb_next;
    end else begin
      RW_valid      <= 1'b0;
      RW_PC         <= '0;
      RW_Ld_Result  <= '0;
      RW_ALU_Result <= '0;
      RW_IR         <= '0;
      RW_controlBus <= '0;
    end
  end

`ifdef MA_MISALIGN_TRAP_EN
  // Sticky fault flag: set by any trapped ld/st, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            misalign <= 1'b0;
    else if (pass && trap) misalign <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: directed self-checking bench for ma_stage.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_ma_stage;

  localparam int DATA_W = 32;
  localparam int CB_W   = 22;

  localparam logic [CB_W-1:0] CB_ST = 22'h000001;
  localparam logic [CB_W-1:0] CB_LD = 22'h000002;
  localparam logic [CB_W-1:0] CB_WB = 22'h000040;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_PC;
  logic [DATA_W-1:0] in_ALU_Result;
  logic [DATA_W-1:0] in_op2;
  logic [DATA_W-1:0] in_IR;
  logic [CB_W-1:0]   in_controlBus;
  logic              ma_stall;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              RW_valid;
  logic [DATA_W-1:0] RW_PC;
  logic [DATA_W-1:0] RW_Ld_Result;
  logic [DATA_W-1:0] RW_ALU_Result;
  logic [DATA_W-1:0] RW_IR;
  logic [CB_W-1:0]   RW_controlBus;
`ifdef MA_MISALIGN_TRAP_EN
  logic              misalign;
`endif

  int compare_count  = 0;
  int mismatch_count = 0;
  int req_cycles;

  ma_stage #(.DATA_W(DATA_W), .CB_W(CB_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_PC         (in_PC),
    .in_ALU_Result (in_ALU_Result),
    .in_op2        (in_op2),
    .in_IR         (in_IR),
    .in_controlBus (in_controlBus),
    .ma_stall      (ma_stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .RW_valid      (RW_valid),
    .RW_PC         (RW_PC),
    .RW_Ld_Result  (RW_Ld_Result),
    .RW_ALU_Result (RW_ALU_Result),
    .RW_IR         (RW_IR),
    .RW_controlBus (RW_controlBus)
`ifdef MA_MISALIGN_TRAP_EN
    ,
    .misalign      (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] pc,
                               input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] op2,
                               input logic [DATA_W-1:0] ir, input logic [CB_W-1:0] cb);
    in_valid      = v;
    in_PC         = pc;
    in_ALU_Result = alu;
    in_op2        = op2;
    in_IR         = ir;
    in_controlBus = cb;
  endtask

  // Advance one edge, then step to the input-drive point just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point: mid-cycle, well away from the rising edge.
  task automatic settle();
    #3;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);

    // Reset state
    #12;
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_RW_valid", 64'(RW_valid), 64'd0);
    checkOutput("rst_RW_cb", 64'(RW_controlBus), 64'd0);
    checkOutput("rst_stall", 64'(ma_stall), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD with isWb: one-cycle pass-through, never stalls
    applyStimulus(1'b1, 32'h0000_0100, 32'h0000_0010, 32'h0, 32'h0800_0000, CB_WB);
    settle();
    checkOutput("add_stall", 64'(ma_stall), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    settle();
    checkOutput("add_RW_valid", 64'(RW_valid), 64'd1);
    checkOutput("add_RW_ALU", 64'(RW_ALU_Result), 64'h10);
    checkOutput("add_RW_Ld", 64'(RW_Ld_Result), 64'h0);
    checkOutput("add_RW_PC", 64'(RW_PC), 64'h100);
    checkOutput("add_RW_cb", 64'(RW_controlBus), 64'(CB_WB));
    checkOutput("add_mem_req", 64'(mem_req), 64'd0);
    tick();
    settle();
    checkOutput("bubble_RW_valid", 64'(RW_valid), 64'd0);
    checkOutput("bubble_RW_cb", 64'(RW_controlBus), 64'd0);

    // LD at 0x40, ack after three wait cycles with 0xDEADBEEF
    applyStimulus(1'b1, 32'h0000_0104, 32'h0000_0040, 32'h5555_5555, 32'h1000_0000, CB_LD | CB_WB);
    settle();
    checkOutput("ld_stall_comb", 64'(ma_stall), 64'd1);
    checkOutput("ld_req_not_comb", 64'(mem_req), 64'd0);
    req_cycles = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      if (mem_req) req_cycles++;
      checkOutput("ld_wait_stall", 64'(ma_stall), 64'd1);
      checkOutput("ld_wait_RW_cb", 64'(RW_controlBus), 64'd0);
      checkOutput("ld_wait_RW_valid", 64'(RW_valid), 64'd0);
      tick();
    end
    checkOutput("ld_we", 64'(mem_we), 64'd0);
    checkOutput("ld_addr", 64'(mem_addr), 64'h40);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    settle();
    if (mem_req) req_cycles++;
    checkOutput("ld_ack_stall", 64'(ma_stall), 64'd0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    settle();
    checkOutput("ld_req_cycles", 64'(req_cycles), 64'd4);
    checkOutput("ld_RW_Ld", 64'(RW_Ld_Result), 64'hDEAD_BEEF);
    checkOutput("ld_RW_valid", 64'(RW_valid), 64'd1);
    checkOutput("ld_RW_PC", 64'(RW_PC), 64'h104);
    checkOutput("ld_req_drop", 64'(mem_req), 64'd0);
    tick();

    // ST at 0x44, ack in first WAIT cycle; rdata is garbage and must be ignored
    applyStimulus(1'b1, 32'h0000_0108, 32'h0000_0044, 32'h1234_5678, 32'h1800_0000, CB_ST);
    tick();
    settle();
    checkOutput("st_req", 64'(mem_req), 64'd1);
    checkOutput("st_we", 64'(mem_we), 64'd1);
    checkOutput("st_addr", 64'(mem_addr), 64'h44);
    checkOutput("st_wdata", 64'(mem_wdata), 64'h1234_5678);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    settle();
    checkOutput("st_RW_valid", 64'(RW_valid), 64'd1);
    checkOutput("st_RW_Ld", 64'(RW_Ld_Result), 64'h0);
    checkOutput("st_RW_PC", 64'(RW_PC), 64'h108);

    // mem_ack while IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    settle();
    checkOutput("idle_ack_req", 64'(mem_req), 64'd0);
    checkOutput("idle_ack_RW_valid", 64'(RW_valid), 64'd0);
    tick();

    // isSt and isLd both set: treated as a store
    applyStimulus(1'b1, 32'h0000_010C, 32'h0000_0048, 32'hA5A5_A5A5, 32'h0, CB_ST | CB_LD);
    tick();
    settle();
    checkOutput("both_we", 64'(mem_we), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    settle();
    checkOutput("both_RW_Ld", 64'(RW_Ld_Result), 64'h0);
    tick();

    // LD immediately followed by ST
    applyStimulus(1'b1, 32'h0000_0200, 32'h0000_0080, 32'h0, 32'h1000_0000, CB_LD | CB_WB);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 1'b0;
    applyStimulus(1'b1, 32'h0000_0204, 32'h0000_0084, 32'h7777_0000, 32'h1800_0000, CB_ST);
    settle();
    checkOutput("b2b_gap_req", 64'(mem_req), 64'd0);
    checkOutput("b2b_gap_stall", 64'(ma_stall), 64'd1);
    checkOutput("b2b_first_PC", 64'(RW_PC), 64'h200);
    checkOutput("b2b_first_Ld", 64'(RW_Ld_Result), 64'hCAFE_0001);
    tick();
    settle();
    checkOutput("b2b_second_req", 64'(mem_req), 64'd1);
    checkOutput("b2b_second_we", 64'(mem_we), 64'd1);
    checkOutput("b2b_second_addr", 64'(mem_addr), 64'h84);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    settle();
    checkOutput("b2b_second_PC", 64'(RW_PC), 64'h204);
    checkOutput("b2b_second_valid", 64'(RW_valid), 64'd1);
    tick();

    // Halt passes through like a non-memory instruction
    applyStimulus(1'b1, 32'h0000_0300, 32'h0, 32'h0, 32'hF800_0000, '0);
    settle();
    checkOutput("halt_stall", 64'(ma_stall), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    settle();
    checkOutput("halt_RW_IR", 64'(RW_IR), 64'hF800_0000);
    checkOutput("halt_RW_valid", 64'(RW_valid), 64'd1);
    tick();

    // Reset asserted in WAIT abandons the access immediately
    applyStimulus(1'b1, 32'h0000_0400, 32'h0000_00C0, 32'h0, 32'h1000_0000, CB_LD | CB_WB);
    tick();
    settle();
    checkOutput("rstw_req_before", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_req", 64'(mem_req), 64'd0);
    checkOutput("rstw_RW_valid", 64'(RW_valid), 64'd0);
    checkOutput("rstw_RW_cb", 64'(RW_controlBus), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h0000_0500, 32'h0000_00D0, 32'h0, 32'h1000_0000, CB_LD);
    settle();
    checkOutput("rstw_idle_stall", 64'(ma_stall), 64'd1);
    tick();
    settle();
    checkOutput("rstw_new_req", 64'(mem_req), 64'd1);
    checkOutput("rstw_new_addr", 64'(mem_addr), 64'hD0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_1111;
    tick();
    mem_ack = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    settle();
    checkOutput("rstw_new_Ld", 64'(RW_Ld_Result), 64'h1111);
    tick();

`ifdef MA_MISALIGN_TRAP_EN
    // Misaligned LD: no request, no stall, isWb cleared, sticky flag
    checkOutput("mis_flag_clear", 64'(misalign), 64'd0);
    applyStimulus(1'b1, 32'h0000_0600, 32'h0000_0042, 32'h0, 32'h1000_0000, CB_LD | CB_WB);
    settle();
    checkOutput("mis_stall", 64'(ma_stall), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    settle();
    checkOutput("mis_req", 64'(mem_req), 64'd0);
    checkOutput("mis_flag", 64'(misalign), 64'd1);
    checkOutput("mis_RW_valid", 64'(RW_valid), 64'd1);
    checkOutput("mis_RW_cb", 64'(RW_controlBus), 64'(CB_LD));
    checkOutput("mis_RW_Ld", 64'(RW_Ld_Result), 64'h0);
    tick();
    settle();
    checkOutput("mis_sticky", 64'(misalign), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Sits between EX and RW.
- Takes the EX result bundle, performs load/store against data memory over a req/ack handshake, and stalls upstream while memory is busy.
- Registers the bundle into the MA/RW latch that drives the RW stage inputs: PC, Ld_Result, ALU_Result, IR and controlBus.

Parameters:
- DATA_W, 32, width of PC, IR, ALU result, operand and memory data.
- CB_W, 22, control bus width. Bit 0 = isSt, bit 1 = isLd, bit 6 = isWb, bit 8 = isCall.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX bundle valid.
- in_PC  in  DATA_W  instruction PC.
- in_ALU_Result  in  DATA_W  ALU result; this is the memory address for ld/st.
- in_op2  in  DATA_W  store data.
- in_IR  in  DATA_W  instruction word.
- in_controlBus  in  CB_W  decoded control bits.
- ma_stall  out  1  upstream must hold all in_* stable while high.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data; valid when mem_ack = 1.
- mem_ack  in  1  single-cycle completion pulse.
- RW_valid  out  1  MA/RW latch holds a real instruction.
- RW_PC, RW_Ld_Result, RW_ALU_Result, RW_IR  out  DATA_W each  latch contents.
- RW_controlBus  out  CB_W  latch control bits.
- misalign  out  1  sticky alignment-fault flag. Present only with the optional feature.

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE.
  - All RW_* outputs and RW_valid are 0.
  - mem_req, mem_we, mem_addr and mem_wdata are 0.
  - Reset asserted mid-transaction abandons the access; mem_req drops immediately.
- Memory operation: is_mem = in_valid & (controlBus[0] | controlBus[1]).
  - If both isSt and isLd are set, the access is treated as a store.
- FSM states: IDLE, WAIT.
- IDLE, in_valid = 0: latch loads a bubble next edge (RW_valid = 0, RW_controlBus = 0, so isWb = 0).
- IDLE, non-memory instruction:
  - Next edge latches the bundle with RW_Ld_Result = 0 and RW_valid = 1.
  - ma_stall = 0; latency is 1 cycle.
- IDLE, is_mem:
  - ma_stall = 1 combinationally.
  - Next edge: state goes to WAIT; registered mem_req = 1; mem_we = isSt; mem_addr = in_ALU_Result; mem_wdata = in_op2.
  - The latch loads a bubble on that edge.
- WAIT, mem_ack = 0: hold mem_req and all mem_* stable, ma_stall = 1, latch loads bubbles.
- WAIT, mem_ack = 1:
  - ma_stall = 0 in that cycle.
  - Next edge: latch loads the bundle with RW_Ld_Result = mem_rdata for a load, 0 for a store; RW_valid = 1; mem_req = 0; state goes to IDLE.
  - Memory op latency is 2 + N cycles, where N = cycles waiting for ack. The minimum is 2.
- Back-to-back memory ops: the next op is seen in IDLE on the cycle after the ack edge. There is one IDLE cycle between requests.
- mem_ack while in IDLE is ignored.
- mem_req never asserts combinationally from in_*.
- Halt instruction (IR[31:27] = 5'b11111) passes through like a non-memory instruction.

Optional Feature:
- Macro: MA_MISALIGN_TRAP_EN.
- Defined:
  - A ld/st with in_ALU_Result[1:0] != 0 issues no memory request and causes no stall.
  - It is latched next edge with RW_controlBus[6] (isWb) forced to 0 and RW_Ld_Result = 0.
  - The sticky misalign output is set to 1; it is cleared only by reset.
- Undefined:
  - No misalign port.
  - The address is passed unmodified and accessed normally.

Test Plan:
- Reset in WAIT with mem_req = 1 -> mem_req, RW_valid and RW_controlBus are all 0 immediately; after release, state is IDLE and a new op issues normally.
- ADD with ALU_Result = 0x0000_0010 and isWb = 1 -> one cycle later RW_ALU_Result = 0x10, RW_Ld_Result = 0, RW_valid = 1, ma_stall never high.
- LD with address 0x0000_0040, ack after 3 wait cycles with rdata = 0xDEAD_BEEF -> mem_req high for 4 cycles, mem_we = 0; RW_Ld_Result = 0xDEADBEEF the edge after ack; bubbles with RW_controlBus = 0 meanwhile.
- ST with address 0x0000_0044 and op2 = 0x1234_5678, ack in first WAIT cycle -> mem_we = 1, mem_wdata = 0x12345678, RW_Ld_Result = 0, total latency 2.
- LD immediately followed by ST -> exactly one IDLE cycle between mem_req pulses; both reach RW in order.
- With MA_MISALIGN_TRAP_EN: LD at address 0x0000_0042 -> no mem_req, misalign = 1, RW_controlBus[6] = 0, latency 1.
